// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor
//   Passive checker for the 4-road crossing. Watches the eight lamp buses
//   and the pedestrian line driven by the signal controller. It decodes each
//   lamp aspect, tracks per-lamp state and dwell time, and latches the first
//   safety or sequence violation. It never drives the lamps.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   signal_M1..M4 [2:0] main-lane lamps of roads 1-4 (001 red, 010 yellow, 100 green)
//   signal_L1..L4 [2:0] left-turn lamps of roads 1-4
//   signal_pedestrian   1 = walk
//   clr_fault           synchronous clear of the latched fault
//   fault               sticky violation flag
//   fault_code    [2:0] 0 none, 1 encoding, 2 cross-road, 3 walk, 4 sequence,
//                       5 short dwell, 6 idle
//   fault_lamp    [3:0] M1..M4 = 0..3, L1..L4 = 4..7, pedestrian/none = 8
//   active_road   [2:0] lowest road (1-4) holding green/yellow, 0 if none
//   rotations     [7:0] road-1 main-lane red->green starts, wrapping
module traffic_signal_monitor #(
  parameter int MIN_GREEN  = 5,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_IDLE   = 40,
  parameter int CW         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] signal_M1,
  input  logic [2:0] signal_M2,
  input  logic [2:0] signal_M3,
  input  logic [2:0] signal_M4,
  input  logic [2:0] signal_L1,
  input  logic [2:0] signal_L2,
  input  logic [2:0] signal_L3,
  input  logic [2:0] signal_L4,
  input  logic       signal_pedestrian,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] fault_lamp,
  output logic [2:0] active_road,
  output logic [7:0] rotations
);

  localparam logic [2:0] RED       = 3'b001;
  localparam logic [2:0] YEL       = 3'b010;
  localparam logic [2:0] GRN       = 3'b100;
  localparam logic [3:0] LAMP_NONE = 4'd8;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == RED) || (v == YEL) || (v == GRN);
  endfunction

  // Only the three skips of the red->green->yellow->red ring are illegal.
  function automatic logic is_illegal(input logic [2:0] from, input logic [2:0] to);
    return ((from == GRN) && (to == RED)) ||
           ((from == YEL) && (to == GRN)) ||
           ((from == RED) && (to == YEL));
  endfunction

  // Index 0..3 = M1..M4, 4..7 = L1..L4, so lamp i belongs to road (i % 4) + 1.
  logic [7:0][2:0] lamp_in;
  assign lamp_in = {signal_L4, signal_L3, signal_L2, signal_L1,
                    signal_M4, signal_M3, signal_M2, signal_M1};

  logic [7:0][2:0]    samp_q;
  logic               walk_q;
  logic [7:0][2:0]    prev_q, prev_d;
  logic [7:0][CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0]      idle_q, idle_d;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;
  logic [3:0]         lamp_q, lamp_d;
  logic [2:0]         road_q, road_d;
  logic [7:0]         rot_q, rot_d;

  logic [7:0] valid, act;
  logic [3:0] road_act;
  logic [2:0] lead_road;
  logic       bad_hit, cross_hit, walk_hit, seq_hit, dwl_hit, idle_hit, all_red;
  logic [3:0] bad_idx, cross_idx, seq_idx, dwl_idx;
  logic [2:0] det_code;
  logic [3:0] det_lamp;

  // ---- stage 1: sample all nine inputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= {8{RED}};
      walk_q <= 1'b0;
    end else begin
      samp_q <= lamp_in;
      walk_q <= signal_pedestrian;
    end
  end

  // ---- stage 2: judge sample against previous state ----
  always_comb begin
    valid     = '0;
    act       = '0;
    lead_road = 3'd0;
    bad_hit   = 1'b0;
    bad_idx   = LAMP_NONE;
    cross_hit = 1'b0;
    cross_idx = LAMP_NONE;
    seq_hit   = 1'b0;
    seq_idx   = LAMP_NONE;
    dwl_hit   = 1'b0;
    dwl_idx   = LAMP_NONE;
    prev_d    = prev_q;
    dwell_d   = dwell_q;

    for (int i = 0; i < 8; i++) begin
      valid[i] = is_onehot(samp_q[i]);
      act[i]   = valid[i] && (samp_q[i] != RED);
    end
    road_act = act[3:0] | act[7:4];

    // Lowest active road is treated as the legitimate holder of the crossing.
    for (int r = 3; r >= 0; r--) begin
      if (road_act[r]) lead_road = 3'(r + 1);
    end

    // Descending scans so the lowest lamp index is the one left recorded.
    for (int i = 7; i >= 0; i--) begin
      if (!valid[i]) begin
        bad_hit = 1'b1;
        bad_idx = 4'(i);
      end
      if (act[i] && (3'((i % 4) + 1) != lead_road)) begin
        cross_hit = 1'b1;
        cross_idx = 4'(i);
      end
      if (valid[i] && is_illegal(prev_q[i], samp_q[i])) begin
        seq_hit = 1'b1;
        seq_idx = 4'(i);
      end
      if (valid[i] &&
          (((prev_q[i] == GRN) && (samp_q[i] == YEL) && (dwell_q[i] < CW'(MIN_GREEN))) ||
           ((prev_q[i] == YEL) && (samp_q[i] == RED) && (dwell_q[i] < CW'(MIN_YELLOW))))) begin
        dwl_hit = 1'b1;
        dwl_idx = 4'(i);
      end
    end

    // Badly encoded lamps keep their last valid state and dwell.
    for (int i = 0; i < 8; i++) begin
      if (valid[i]) begin
        prev_d[i]  = samp_q[i];
        dwell_d[i] = (samp_q[i] != prev_q[i]) ? CW'(1) : sat_inc(dwell_q[i]);
      end
    end

    walk_hit = walk_q && (|act);
    all_red  = (samp_q == {8{RED}}) && !walk_q;
    idle_d   = all_red ? sat_inc(idle_q) : '0;
    idle_hit = (idle_d >= CW'(MAX_IDLE));

    det_code = 3'd0;
    det_lamp = LAMP_NONE;
    if (bad_hit) begin
      det_code = 3'd1;
      det_lamp = bad_idx;
    end else if (cross_hit) begin
      det_code = 3'd2;
      det_lamp = cross_idx;
    end else if (walk_hit) begin
      det_code = 3'd3;
    end else if (seq_hit) begin
      det_code = 3'd4;
      det_lamp = seq_idx;
    end else if (dwl_hit) begin
      det_code = 3'd5;
      det_lamp = dwl_idx;
    end else if (idle_hit) begin
      det_code = 3'd6;
    end

    // A fresh detection beats a clear arriving in the same cycle.
    fault_d = fault_q;
    code_d  = code_q;
    lamp_d  = lamp_q;
    if ((det_code != 3'd0) && (!fault_q || clr_fault)) begin
      fault_d = 1'b1;
      code_d  = det_code;
      lamp_d  = det_lamp;
    end else if (clr_fault) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
      lamp_d  = LAMP_NONE;
    end

    road_d = lead_road;
    rot_d  = rot_q;
    if (valid[0] && (prev_q[0] == RED) && (samp_q[0] == GRN)) rot_d = rot_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= {8{RED}};
      dwell_q <= '0;
      idle_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      lamp_q  <= LAMP_NONE;
      road_q  <= 3'd0;
      rot_q   <= 8'd0;
    end else begin
      prev_q  <= prev_d;
      dwell_q <= dwell_d;
      idle_q  <= idle_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      lamp_q  <= lamp_d;
      road_q  <= road_d;
      rot_q   <= rot_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_lamp  = lamp_q;
  assign active_road = road_q;
  assign rotations   = rot_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: directed lamp sequences, a colour-level
// reference model compared every cycle, and hand-computed literal checks.
module tb_traffic_signal_monitor;

  localparam int MIN_GREEN  = 5;
  localparam int MIN_YELLOW = 2;
  localparam int MAX_IDLE   = 40;
  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] lamp [8];
  logic       walk = 1'b0;
  logic       clr  = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_lamp;
  logic [2:0] active_road;
  logic [7:0] rotations;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_signal_monitor dut (
    .clk              (clk),
    .reset            (rst),
    .signal_M1        (lamp[0]),
    .signal_M2        (lamp[1]),
    .signal_M3        (lamp[2]),
    .signal_M4        (lamp[3]),
    .signal_L1        (lamp[4]),
    .signal_L2        (lamp[5]),
    .signal_L3        (lamp[6]),
    .signal_L4        (lamp[7]),
    .signal_pedestrian(walk),
    .clr_fault        (clr),
    .fault            (fault),
    .fault_code       (fault_code),
    .fault_lamp       (fault_lamp),
    .active_road      (active_road),
    .rotations        (rotations)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (colours: 0 red, 1 yellow, 2 green, -1 bad)
  logic [2:0] ms_lamp [8];
  logic       ms_walk;
  int m_col[8];
  int m_dwell[8];
  int m_idle;
  int m_fault, m_code, m_lamp, m_road, m_rot;

  function automatic int colour(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  // Legal moves are holds or one step forward around red->green->yellow->red.
  function automatic bit legal_move(input int from, input int to);
    int fwd;
    fwd = (from == 0) ? 2 : (from == 2) ? 1 : 0;
    return (to == from) || (to == fwd);
  endfunction

  function automatic int min_dwell(input int from, input int to);
    if (from == 2 && to == 1) return MIN_GREEN;
    if (from == 1 && to == 0) return MIN_YELLOW;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      ms_lamp[i] = R;
      m_col[i]   = 0;
      m_dwell[i] = 0;
    end
    ms_walk = 1'b0;
    m_idle  = 0;
    m_fault = 0;
    m_code  = 0;
    m_lamp  = 8;
    m_road  = 0;
    m_rot   = 0;
  endtask

  task automatic model_eval();
    int c[8];
    int lead, code, who, nred;
    int hit[7];
    bit any_on;
    lead   = 0;
    any_on = 0;
    nred   = 0;
    for (int k = 0; k < 7; k++) hit[k] = -1;
    for (int i = 0; i < 8; i++) c[i] = colour(ms_lamp[i]);
    for (int r = 4; r >= 1; r--)
      if (c[r-1] > 0 || c[r+3] > 0) lead = r;
    for (int i = 7; i >= 0; i--) begin
      if (c[i] < 0) hit[1] = i;
      if (c[i] > 0 && (i % 4) + 1 != lead) hit[2] = i;
      if (c[i] > 0) any_on = 1;
      if (c[i] == 0) nred++;
      if (c[i] >= 0 && !legal_move(m_col[i], c[i])) hit[4] = i;
      if (c[i] >= 0 && c[i] != m_col[i] && m_dwell[i] < min_dwell(m_col[i], c[i])) hit[5] = i;
    end
    if (ms_walk && any_on) hit[3] = 8;
    m_idle = (nred == 8 && !ms_walk) ? ((m_idle < 255) ? m_idle + 1 : 255) : 0;
    if (m_idle >= MAX_IDLE) hit[6] = 8;
    code = 0;
    who  = 8;
    for (int k = 6; k >= 1; k--)
      if (hit[k] >= 0) begin
        code = k;
        who  = hit[k];
      end
    if (c[0] == 2 && m_col[0] == 0) m_rot = (m_rot + 1) % 256;
    for (int i = 0; i < 8; i++)
      if (c[i] >= 0) begin
        m_dwell[i] = (c[i] != m_col[i]) ? 1 : ((m_dwell[i] < 255) ? m_dwell[i] + 1 : 255);
        m_col[i]   = c[i];
      end
    m_road = lead;
    if (code != 0 && (m_fault == 0 || clr)) begin
      m_fault = 1;
      m_code  = code;
      m_lamp  = who;
    end else if (clr) begin
      m_fault = 0;
      m_code  = 0;
      m_lamp  = 8;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        model_eval();
        for (int i = 0; i < 8; i++) ms_lamp[i] = lamp[i];
        ms_walk = walk;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cyc_fault", fault, m_fault);
        chk("cyc_code", fault_code, m_code);
        chk("cyc_lamp", fault_lamp, m_lamp);
        chk("cyc_road", active_road, m_road);
        chk("cyc_rot", rotations, m_rot);
      end
    end
  end

  // ---------------- stimulus
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_road(input int r, input logic [2:0] v);
    lamp[r-1] = v;
    lamp[r+3] = v;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) lamp[i] = R;
    step(2);
    rst = 1'b0;
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_lamp", fault_lamp, 8);
    chk("rst_road", active_road, 0);
    chk("rst_rot", rotations, 0);

    // legal rotation through all four roads
    for (int r = 1; r <= 4; r++) begin
      walk = 1'b0;
      set_road(r, G);
      step(2);
      chk("legal_road", active_road, r);
      step(4);
      set_road(r, Y);
      step(2);
      set_road(r, R);
      walk = 1'b1;
      step(3);
    end
    chk("legal_fault", fault, 0);
    chk("legal_rot", rotations, 1);

    // cross-road green
    walk = 1'b0;
    lamp[0] = G;
    step(3);
    lamp[2] = G;
    step(1);
    chk("cross_early", fault, 0);
    step(1);
    chk("cross_fault", fault, 1);
    chk("cross_code", fault_code, 2);
    chk("cross_lamp", fault_lamp, 2);
    step(4);
    lamp[0] = Y;
    lamp[2] = Y;
    step(2);
    lamp[0] = R;
    lamp[2] = R;
    walk = 1'b1;
    step(3);
    pulse_clear();
    chk("clr_fault", fault, 0);
    chk("clr_code", fault_code, 0);
    chk("clr_lamp", fault_lamp, 8);

    // short green on M2, then a yellow->green while latched
    walk = 1'b0;
    lamp[1] = G;
    step(3);
    lamp[1] = Y;
    step(2);
    chk("short_code", fault_code, 5);
    chk("short_lamp", fault_lamp, 1);
    lamp[1] = G;
    step(2);
    chk("sticky_code", fault_code, 5);
    step(4);
    lamp[1] = Y;
    step(2);
    lamp[1] = R;
    walk = 1'b1;
    step(3);
    pulse_clear();

    // bad encoding on L4, then a legal L4 cycle
    lamp[7] = 3'b110;
    step(1);
    lamp[7] = R;
    step(1);
    chk("enc_code", fault_code, 1);
    chk("enc_lamp", fault_lamp, 7);
    pulse_clear();
    walk = 1'b0;
    lamp[7] = G;
    step(6);
    lamp[7] = Y;
    step(2);
    lamp[7] = R;
    walk = 1'b1;
    step(3);
    chk("enc_after", fault_code, 0);

    // walk during L2 yellow
    walk = 1'b0;
    lamp[5] = G;
    step(5);
    lamp[5] = Y;
    walk = 1'b1;
    step(2);
    chk("walk_code", fault_code, 3);
    chk("walk_lamp", fault_lamp, 8);
    lamp[5] = R;
    step(3);
    pulse_clear();

    // idle: 40 all-red no-walk samples
    walk = 1'b0;
    step(40);
    chk("idle_early", fault, 0);
    step(1);
    chk("idle_code", fault_code, 6);
    chk("idle_lamp", fault_lamp, 8);
    walk = 1'b1;
    step(1);
    pulse_clear();
    chk("idle_clr", fault, 0);

    // asynchronous reset in the middle of road 3 green
    walk = 1'b0;
    set_road(3, G);
    step(3);
    chk("pre_rst_road", active_road, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_road", active_road, 0);
    chk("arst_rot", rotations, 0);
    chk("arst_lamp", fault_lamp, 8);
    @(negedge clk);
    rst = 1'b0;
    step(5);
    chk("post_rst_fault", fault, 0);
    chk("post_rst_road", active_road, 3);
    step(1);
    set_road(3, Y);
    step(2);
    set_road(3, R);
    walk = 1'b1;
    step(3);
    chk("post_rst_end", fault, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_signal_monitor.md
Name: traffic_signal_monitor

Overview:
- Passive receive-side checker for the 4-road crossing. It consumes the eight lamp buses and the pedestrian line that the traffic signal controller drives.
- Decodes each lamp's aspect, tracks per-lamp state and dwell time, and latches the first safety or sequence violation.
- Sits beside the controller in the system and in benches; it never drives lamps.

Parameters:
- MIN_GREEN, 5, minimum sampled cycles a lamp must stay green before going yellow.
- MIN_YELLOW, 2, minimum sampled cycles a lamp must stay yellow before going red.
- MAX_IDLE, 40, consecutive all-red, no-walk cycles that raise an idle fault.
- CW, 8, width of the dwell and idle counters; counters saturate at 2^CW-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- signal_M1..signal_M4  input  3 each  main-lane lamps, roads 1-4.
- signal_L1..signal_L4  input  3 each  left-turn lamps, roads 1-4.
- signal_pedestrian  input  1  1 = walk.
- clr_fault  input  1  synchronous clear of the latched fault.
- fault  output  1  sticky violation flag.
- fault_code  output  3  0 none, 1 bad encoding, 2 cross-road green, 3 walk conflict, 4 bad sequence, 5 short dwell, 6 idle.
- fault_lamp  output  4  offending lamp: M1..M4 = 0..3, L1..L4 = 4..7, pedestrian/none = 8.
- active_road  output  3  one-hot-decoded road (1-4) currently holding any green/yellow; 0 if none.
- rotations  output  8  count of road-1 main-lane red->green starts; wraps 255->0.

Behaviour:
- Lamp encoding is one-hot: 3'b001 red, 3'b010 yellow, 3'b100 green. Any other value is a bad encoding.
- Reset values: fault=0, fault_code=0, fault_lamp=8, active_road=0, rotations=0. Input sample registers, lamp previous states = red. Dwell counters = 0, idle counter = 0.
- Stage 1 registers all nine inputs (sample S). Stage 2 compares S against the stored previous state P and registers the results.
- Latency: an input presented before edge N is sampled at N. Its fault appears on the outputs after edge N+1.
- Dwell per lamp:
  - Counter resets to 1 on the sample where the state changes, otherwise increments, saturating.
  - The check uses the dwell value held before the change.
- Checks evaluated each sample, lowest code wins if several fire. Within one code, the lowest fault_lamp index wins.
  - Code 1: any lamp not one-hot.
  - Code 2: green or yellow present on lamps of two different roads. M_i with L_i of the same road is legal.
  - Code 3: walk=1 while any lamp is green or yellow.
  - Code 4: an illegal transition. Legal set is red->green, green->yellow, yellow->red, plus holds. Green->red, yellow->green and red->yellow are illegal.
  - Code 5: green->yellow with green dwell < MIN_GREEN, or yellow->red with yellow dwell < MIN_YELLOW.
  - Code 6: idle counter reaches MAX_IDLE. The idle counter runs while all lamps are red and walk=0, and clears otherwise.
- Lamps with bad encoding do not update P or dwell. Sequence checks resume from the last valid state.
- Latching: the first fault sets fault/fault_code/fault_lamp. Later faults are ignored while fault=1.
- clr_fault=1 clears fault, fault_code (0) and fault_lamp (8) on the next edge. If a new fault is detected in that same cycle, the new fault wins.
- active_road, rotations and dwell tracking continue regardless of the fault state.
- active_road is registered from S in the same cycle as the checks. On a code-2 sample it holds the lowest-numbered active road.
- Reset asserted mid-operation immediately forces all reset values. The first post-reset sample is judged against all-red P.

Test Plan:
- Legal cycle: road 1 M1=L1=green for 6, yellow for 2, red; then roads 2, 3, 4 the same way, with walk for 3 cycles between roads -> fault stays 0, rotations=1, active_road steps 1,2,3,4.
- M1 green held while M3 goes green -> fault=1, code=2, lamp=2, two edges after M3 is applied. Then clr_fault with legal inputs -> fault=0, code=0.
- M2 green for 3 cycles then yellow (MIN_GREEN=5) -> code=5, lamp=1. Next, with the fault set, M2 yellow->green -> code stays 5.
- L4=3'b110 for one cycle -> code=1, lamp=7. A subsequent legal L4 sequence causes no code-4 fault after the clear.
- Walk=1 while L2 yellow -> code=3, lamp=8. Separately, all red with walk=0 for 40 cycles -> code=6 on the 40th sample.
- Reset pulse mid-green of road 3 -> outputs return to reset values asynchronously. Road 3 green continuing after reset is accepted as red->green (no fault).
